// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and its controller.
// The datapath side is master, the hazard controller is slave.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      id_ins;
    logic             ex_memread;
    logic [4:0]       ex_rd;
    logic             ex_branch_taken;
    logic [63:0]      ex_target;
    logic             mem_busy;
    logic             halt_req;
    logic             step_req;
    logic             resume_req;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             pipe_hold;
    logic             pc_sel;
    logic [63:0]      pc_target;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_ins, ex_memread, ex_rd,
        output ex_branch_taken, ex_target,
        output mem_busy,
        output halt_req, step_req, resume_req,
        input  pc_write, ifid_write, ifid_flush,
        input  idex_bubble, pipe_hold,
        input  pc_sel, pc_target, halted,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_ins, ex_memread, ex_rd,
        input  ex_branch_taken, ex_target,
        input  mem_busy,
        input  halt_req, step_req, resume_req,
        output pc_write, ifid_write, ifid_flush,
        output idex_bubble, pipe_hold,
        output pc_sel, pc_target, halted,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch / memory-freeze hazard control with debug
// run-control (RUN, HALTED, STEP) and saturating event counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;

    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_hold;
    logic pc_sel;
    logic halted;

    assign opcode = hz.id_ins[6:0];
    assign rs1    = hz.id_ins[19:15];
    assign rs2    = hz.id_ins[24:20];

    assign rs1_used = !((opcode == OP_LUI) ||
                        (opcode == OP_AUIPC) ||
                        (opcode == OP_JAL));
    assign rs2_used = (opcode == OP_RTYPE) ||
                      (opcode == OP_STORE) ||
                      (opcode == OP_BRANCH);

    assign load_use = hz.ex_memread &&
                      (hz.ex_rd != 5'd0) &&
                      ((rs1_used && (rs1 == hz.ex_rd)) ||
                       (rs2_used && (rs2 == hz.ex_rd)));

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        pc_sel      = 1'b0;
        halted      = 1'b0;
        if (state_q == HALTED) begin
            pipe_hold = 1'b1;
            halted    = 1'b1;
        end else if (hz.mem_busy) begin
            pipe_hold = 1'b1;
        end else if (hz.ex_branch_taken) begin
            // Branch beats load-use: the stalled instruction is squashed anyway.
            pc_sel      = 1'b1;
            pc_write    = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            idex_bubble = 1'b1;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (hz.halt_req) state_d = HALTED;
            end
            HALTED: begin
                if (hz.resume_req)    state_d = RUN;
                else if (hz.step_req) state_d = STEP;
            end
            STEP: begin
                if (!hz.mem_busy) state_d = HALTED;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((state_q != HALTED) && !pc_write &&
            (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (ifid_flush && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.pipe_hold   = pipe_hold;
    assign hz.pc_sel      = pc_sel;
    assign hz.pc_target   = hz.ex_target;
    assign hz.halted      = halted;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.flush_cnt   = flush_cnt_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port id_ins  input  32  instruction currently held in the IF/ID register.
REQ-005 SHALL have port ex_memread  input  1  instruction in EX is a load.
REQ-006 SHALL have port ex_rd  input  5  destination register of the instruction in EX.
REQ-007 SHALL have port ex_branch_taken  input  1  branch or jump in EX resolved taken.
REQ-008 SHALL have port ex_target  input  64  redirect address from EX.
REQ-009 SHALL have port mem_busy  input  1  data memory not ready; the pipeline must freeze.
REQ-010 SHALL have port halt_req, step_req, resume_req  input  1 each  debug run-control pulses.
REQ-011 SHALL have port pc_write  output  1  PC register load enable.
REQ-012 SHALL have port ifid_write  output  1  IF/ID load enable.
REQ-013 SHALL have port ifid_flush  output  1  IF/ID clears to 0 at the next edge.
REQ-014 SHALL have port idex_bubble  output  1  ID/EX loads a NOP at the next edge.
REQ-015 SHALL have port pipe_hold  output  1  ID/EX, EX/MEM and MEM/WB hold their contents.
REQ-016 SHALL have port pc_sel, pc_target  output  1, 64  select redirect address; pc_target = ex_target.
REQ-017 SHALL have port halted  output  1  FSM is in HALTED.
REQ-018 SHALL have port stall_cnt, flush_cnt  output  CNT_W each  saturating event counters.

Function
REQ-019 SHALL decode rs1 = id_ins[19:15], rs2 = id_ins[24:20], opcode = id_ins[6:0].
REQ-020 SHALL treat rs1 as used for all opcodes except 0110111, 0010111 and 1101111; rs2 as used only for 0110011, 0100011 and 1100011.
REQ-021 SHALL assert load_use when all of the following hold: ex_memread = 1, ex_rd != 0, and a used rs1 or rs2 equals ex_rd.
REQ-022 SHALL implement FSM states RUN, HALTED and STEP, encoded as state register bits.
REQ-023 SHALL generate all control outputs combinationally from the current state and inputs (same-cycle action).
REQ-024 In RUN or STEP, the control outputs SHALL follow this priority:
- mem_busy: pc_write = 0, ifid_write = 0, pipe_hold = 1; all other controls 0.
- else ex_branch_taken: pc_sel = 1, pc_write = 1, ifid_flush = 1, idex_bubble = 1.
- else load_use: pc_write = 0, ifid_write = 0, idex_bubble = 1.
- else: pc_write = 1, ifid_write = 1; all other controls 0.
REQ-025 When ex_branch_taken and load_use are both asserted, the branch SHALL win; no stall, flush only.
REQ-026 ifid_flush SHALL override ifid_write; ifid_write is 0 whenever ifid_flush = 1.
REQ-027 In HALTED, outputs SHALL be pc_write = 0, ifid_write = 0, pipe_hold = 1, halted = 1, and all other controls 0.
REQ-028 Transitions:
- RUN -> HALTED on halt_req.
- HALTED -> RUN on resume_req.
- HALTED -> STEP on step_req without resume_req; resume_req has priority.
- STEP -> HALTED at the first edge where mem_busy = 0 (one advancing cycle).
- STEP ignores halt_req, step_req and resume_req.
- RUN ignores step_req and resume_req.
REQ-029 stall_cnt SHALL increment by 1 each cycle in RUN or STEP where pc_write = 0, and saturate at all-ones.
REQ-030 flush_cnt SHALL increment by 1 each cycle where ifid_flush = 1, and saturate at all-ones.
REQ-031 pc_target SHALL always equal ex_target, regardless of pc_sel.

Reset
REQ-032 On reset, the block SHALL asynchronously enter RUN and clear stall_cnt and flush_cnt to 0.
- The block SHALL then produce RUN-state outputs; with idle inputs: pc_write = 1, ifid_write = 1, all others 0.
REQ-033 Reset asserted in HALTED or STEP SHALL abort to RUN; no pending step is retained.

Verification
REQ-034 Load-use: ex_memread = 1, ex_rd = 5, id_ins = 0x00528333 (add x6,x5,x5) -> pc_write = 0, ifid_write = 0, idex_bubble = 1, stall_cnt 0 -> 1.
REQ-035 Branch over load-use: same inputs plus ex_branch_taken = 1, ex_target = 0x100 -> pc_sel = 1, pc_target = 0x100, ifid_flush = 1, ifid_write = 0, pc_write = 1, flush_cnt = 1, stall_cnt unchanged.
REQ-036 Memory freeze: mem_busy = 1 for 3 cycles with ex_branch_taken = 1 -> pipe_hold = 1 and no flush for 3 cycles, then flush in the 4th cycle; stall_cnt = 3.
REQ-037 Debug sequence: halt_req -> halted = 1; step_req -> STEP for exactly one cycle with pc_write = 1, then halted = 1; step_req plus resume_req together -> RUN.
REQ-038 Saturation/reset: CNT_W = 2, 5 stall cycles -> stall_cnt = 3; assert reset in HALTED -> halted = 0, stall_cnt = 0 immediately without a clock edge.
